// File: rtl/light_stick_pkg.sv
// Shared types and constants for the light stick song/gesture control.
package light_stick_pkg;

  localparam int SONG_W        = 4;
  localparam int TIMER_W       = 12;
  localparam int NUM_SONGS_DEF = 9;
  localparam int SHAKE_MIN_DEF = 20;
  localparam int SHAKE_MAX_DEF = 60;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PLAYING = 2'd2
  } gesture_state_e;

  function automatic logic [SONG_W-1:0] song_step(
    input logic [SONG_W-1:0] cur,
    input logic              fwd,
    input logic [SONG_W-1:0] top
  );
    logic [SONG_W-1:0] nxt;
    if (fwd) begin
      nxt = (cur == top) ? {{(SONG_W-1){1'b0}}, 1'b1} : cur + {{(SONG_W-1){1'b0}}, 1'b1};
    end else begin
      nxt = (cur == {{(SONG_W-1){1'b0}}, 1'b1}) ? top : cur - {{(SONG_W-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability-count debouncer and rising-edge event pulse
// for one raw asynchronous input.
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_accept;

  assign w_differ = (r_sync2 != o_level);
  assign w_accept = w_differ && (r_cnt == CNT_W'(DEB_CYCLES - 1));

  // Any cycle agreeing with the current level restarts the stability count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      o_level <= 1'b0;
      o_rise  <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      o_rise  <= w_accept && r_sync2;
      if (w_accept) begin
        o_level <= r_sync2;
        r_cnt   <= '0;
      end else if (w_differ) begin
        r_cnt   <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt   <= '0;
      end
    end
  end

endmodule

// File: rtl/song_select_ctrl.sv
// Song selection and two-shake play-start controller: arbitrates debounced
// next/prev events, tracks song_no and runs the shake timing-window FSM.
module song_select_ctrl
  import light_stick_pkg::*;
#(
  parameter int NUM_SONGS  = NUM_SONGS_DEF,
  parameter int DEB_CYCLES = 16,
  parameter int TICK_DIV   = 1000,
  parameter int SHAKE_MIN  = SHAKE_MIN_DEF,
  parameter int SHAKE_MAX  = SHAKE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              next_btn,
  input  logic              prev_btn,
  input  logic              shake_in,
  output logic [SONG_W-1:0] song_no,
  output logic              restart,
  output logic              song_chg,
  output logic              play_start
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic                w_next_ev;
  logic                w_prev_ev;
  logic                w_shake_ev;
  logic                w_next_lvl;
  logic                w_prev_lvl;
  logic                w_shake_lvl;
  logic                w_chg;
  logic                w_tick;
  logic                w_in_window;
  logic [SONG_W-1:0]   w_new_song;
  logic [PRESC_W-1:0]  r_presc;
  logic [TIMER_W-1:0]  r_timer;
  gesture_state_e      r_state;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk(clk), .rst_n(rst_n), .i_raw(next_btn), .o_level(w_next_lvl), .o_rise(w_next_ev)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prev (
    .clk(clk), .rst_n(rst_n), .i_raw(prev_btn), .o_level(w_prev_lvl), .o_rise(w_prev_ev)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_shake (
    .clk(clk), .rst_n(rst_n), .i_raw(shake_in), .o_level(w_shake_lvl), .o_rise(w_shake_ev)
  );

  // Simultaneous next and prev cancel each other out.
  assign w_chg       = w_next_ev ^ w_prev_ev;
  assign w_new_song  = song_step(song_no, w_next_ev, SONG_W'(NUM_SONGS));
  assign w_tick      = (r_presc == PRESC_W'(TICK_DIV - 1));
  assign w_in_window = (r_timer >= TIMER_W'(SHAKE_MIN)) && (r_timer <= TIMER_W'(SHAKE_MAX));

  // Song counter, tick prescaler, gesture timer and gesture FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      song_no    <= SONG_W'(1);
      restart    <= 1'b1;
      song_chg   <= 1'b0;
      play_start <= 1'b0;
      r_presc    <= '0;
      r_timer    <= '0;
      r_state    <= IDLE;
    end else begin
      song_chg   <= 1'b0;
      play_start <= 1'b0;
      r_presc    <= w_tick ? '0 : r_presc + PRESC_W'(1);
      if ((r_state == ARMED) && w_tick && (r_timer != {TIMER_W{1'b1}})) begin
        r_timer <= r_timer + TIMER_W'(1);
      end
      if (w_chg) begin
        song_no  <= w_new_song;
        song_chg <= 1'b1;
        restart  <= 1'b1;
        r_state  <= IDLE;
        r_timer  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            restart <= 1'b1;
            if (w_shake_ev) begin
              r_state <= ARMED;
              r_timer <= '0;
              r_presc <= '0;
            end
          end
          ARMED: begin
            restart <= 1'b1;
            if (w_shake_ev && w_in_window) begin
              r_state    <= PLAYING;
              restart    <= 1'b0;
              play_start <= 1'b1;
            end else if (w_shake_ev) begin
              r_timer <= '0;
              r_presc <= '0;
            end else if (r_timer > TIMER_W'(SHAKE_MAX)) begin
              r_state <= IDLE;
              r_timer <= '0;
            end
          end
          PLAYING: begin
            restart <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            restart <= 1'b1;
            r_timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_select_ctrl.sv
// Scoreboard bench for song_select_ctrl with a short debounce and tick period.
module tb_song_select_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       next_btn = 1'b0;
  logic       prev_btn = 1'b0;
  logic       shake_in = 1'b0;
  logic [3:0] song_no;
  logic       restart;
  logic       song_chg;
  logic       play_start;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_chg = 0;
  int n_play = 0;
  int n_exp_chg = 0;
  int n_exp_play = 0;
  int t_rise = 0;
  int t_base = 0;

  logic [3:0] q_song[$];
  int         q_play[$];
  logic [3:0] exp_song = 4'd1;
  logic       exp_restart = 1'b1;

  song_select_ctrl #(
    .NUM_SONGS(9), .DEB_CYCLES(4), .TICK_DIV(4), .SHAKE_MIN(20), .SHAKE_MAX(60)
  ) dut (
    .clk(clk), .rst_n(rst_n), .next_btn(next_btn), .prev_btn(prev_btn),
    .shake_in(shake_in), .song_no(song_no), .restart(restart),
    .song_chg(song_chg), .play_start(play_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output side of the scoreboard: every pulse must match a queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (song_chg) begin
        n_chg++;
        check_val("chg_excl_play", {31'd0, play_start}, 32'd0);
        check_val("chg_queued", {31'd0, (q_song.size() > 0)}, 32'd1);
        if (q_song.size() > 0) begin
          check_val("chg_song_no", {28'd0, song_no}, {28'd0, q_song.pop_front()});
          check_val("chg_restart", {31'd0, restart}, 32'd1);
        end
      end
      if (play_start) begin
        n_play++;
        check_val("play_queued", {31'd0, (q_play.size() > 0)}, 32'd1);
        check_val("play_restart", {31'd0, restart}, 32'd0);
        if (q_play.size() > 0) void'(q_play.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rel(input int base, input int d);
    while (cyc < base + d) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic n, input logic p, input logic s, input int hold);
    t_rise   = cyc;
    next_btn = n;
    prev_btn = p;
    shake_in = s;
    tick(hold);
    next_btn = 1'b0;
    prev_btn = 1'b0;
    shake_in = 1'b0;
    tick(12);
  endtask

  task automatic expect_song(input logic fwd);
    if (fwd) exp_song = (exp_song == 4'd9) ? 4'd1 : exp_song + 4'd1;
    else     exp_song = (exp_song == 4'd1) ? 4'd9 : exp_song - 4'd1;
    exp_restart = 1'b1;
    q_song.push_back(exp_song);
    n_exp_chg++;
  endtask

  task automatic expect_play();
    exp_restart = 1'b0;
    q_play.push_back(1);
    n_exp_play++;
  endtask

  task automatic settle(input string tag);
    tick(30);
    check_val({tag, "_drained"}, q_song.size() + q_play.size(), 32'd0);
    check_val({tag, "_song"}, {28'd0, song_no}, {28'd0, exp_song});
    check_val({tag, "_restart"}, {31'd0, restart}, {31'd0, exp_restart});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    check_val("rst_song", {28'd0, song_no}, 32'd1);
    check_val("rst_restart", {31'd0, restart}, 32'd1);
    check_val("rst_chg", {31'd0, song_chg}, 32'd0);
    check_val("rst_play", {31'd0, play_start}, 32'd0);
    rst_n = 1'b1;
    tick(5);

    for (int i = 0; i < 9; i++) begin
      expect_song(1'b1);
      press(1'b1, 1'b0, 1'b0, 8);
    end
    settle("wrap");
    expect_song(1'b0);
    press(1'b0, 1'b1, 1'b0, 8);
    settle("prev_from1");

    press(1'b1, 1'b0, 1'b0, 3);
    settle("glitch3");
    expect_song(1'b1);
    press(1'b1, 1'b0, 1'b0, 4);
    settle("hold4");
    expect_song(1'b1);
    press(1'b1, 1'b0, 1'b0, 100);
    settle("hold100");

    // Second shake at timer 30.
    press(1'b0, 1'b0, 1'b1, 8);
    t_base = t_rise;
    wait_rel(t_base, 122);
    expect_play();
    press(1'b0, 1'b0, 1'b1, 8);
    settle("gesture_ok");
    press(1'b0, 1'b0, 1'b1, 8);
    press(1'b0, 1'b0, 1'b1, 8);
    settle("playing_ignores");

    expect_song(1'b1);
    press(1'b1, 1'b0, 1'b0, 8);
    settle("to_idle");

    // Early second shake at timer 10 restarts the window.
    press(1'b0, 1'b0, 1'b1, 8);
    t_base = t_rise;
    wait_rel(t_base, 42);
    press(1'b0, 1'b0, 1'b1, 8);
    t_base = t_rise;
    check_val("early_no_play", {31'd0, restart}, 32'd1);
    wait_rel(t_base, 102);
    expect_play();
    press(1'b0, 1'b0, 1'b1, 8);
    settle("early_then_ok");

    expect_song(1'b1);
    press(1'b1, 1'b0, 1'b0, 8);
    settle("to_idle2");

    // Late second shake (timer 61), then a full timeout.
    press(1'b0, 1'b0, 1'b1, 8);
    t_base = t_rise;
    wait_rel(t_base, 246);
    press(1'b0, 1'b0, 1'b1, 8);
    settle("late_no_play");
    tick(300);
    press(1'b0, 1'b0, 1'b1, 8);
    settle("after_timeout_first");
    t_base = t_rise;
    wait_rel(t_base, 122);
    expect_play();
    press(1'b0, 1'b0, 1'b1, 8);
    settle("after_timeout_ok");

    press(1'b1, 1'b1, 1'b0, 8);
    settle("next_prev_same");

    expect_song(1'b1);
    press(1'b1, 1'b0, 1'b0, 8);
    settle("to_idle3");
    press(1'b0, 1'b0, 1'b1, 8);
    t_base = t_rise;
    wait_rel(t_base, 122);
    expect_song(1'b1);
    press(1'b1, 1'b0, 1'b1, 8);
    settle("chg_beats_shake");

    expect_song(1'b0);
    press(1'b0, 1'b1, 1'b0, 8);
    settle("back_to5");
    check_val("pre_reset_song", {28'd0, song_no}, 32'd5);

    press(1'b0, 1'b0, 1'b1, 8);
    t_base = t_rise;
    tick(40);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_song", {28'd0, song_no}, 32'd1);
    check_val("mid_rst_restart", {31'd0, restart}, 32'd1);
    check_val("mid_rst_chg", {31'd0, song_chg}, 32'd0);
    check_val("mid_rst_play", {31'd0, play_start}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    exp_song = 4'd1;
    exp_restart = 1'b1;
    wait_rel(t_base, 122);
    press(1'b0, 1'b0, 1'b1, 8);
    settle("post_reset");

    check_val("chg_count", n_chg, n_exp_chg);
    check_val("play_count", n_play, n_exp_play);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
